// File: rtl/bist_pkg.sv
// Shared state encoding and width helper for the BIST scheduler and its pattern counter.
package bist_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_INIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_COMPARE = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Bits needed to index 0..value-1, never less than one so single-entry counters still have a bit.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bist_scheduler_if.sv
// Bus between the BIST scheduler and the test access logic / shared TPG-MISR datapath.
// retry_vec exists only when BIST_SCHED_RETRY_EN is defined.
interface bist_scheduler_if #(
  parameter int NCORES = 4,
  parameter int SIG_W  = 8
);

  localparam int IDX_W = bist_pkg::clog2_min1(NCORES);

  logic                      start;
  logic [NCORES-1:0]         core_mask;
  logic [NCORES*SIG_W-1:0]   golden_sig;
  logic [SIG_W-1:0]          misr_sig;
  logic [IDX_W-1:0]          core_sel;
  logic                      tpg_init;
  logic                      tpg_en;
  logic                      busy;
  logic                      done;
  logic [NCORES-1:0]         pass_vec;
  logic                      fail;
`ifdef BIST_SCHED_RETRY_EN
  logic [NCORES-1:0]         retry_vec;
`endif

  modport master (
    output start, core_mask, golden_sig, misr_sig,
`ifdef BIST_SCHED_RETRY_EN
    input  retry_vec,
`endif
    input  core_sel, tpg_init, tpg_en, busy, done, pass_vec, fail
  );

  modport slave (
    input  start, core_mask, golden_sig, misr_sig,
`ifdef BIST_SCHED_RETRY_EN
    output retry_vec,
`endif
    output core_sel, tpg_init, tpg_en, busy, done, pass_vec, fail
  );

endinterface

// File: rtl/bist_pattern_counter.sv
// Counts applied patterns within one session; terminal_o flags the last pattern (NPATTERNS-1).
module bist_pattern_counter #(
  parameter int NPATTERNS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int CNT_W = bist_pkg::clog2_min1(NPATTERNS);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == CNT_W'(NPATTERNS - 1));

endmodule

// File: rtl/bist_scheduler.sv
// Sequences BIST sessions over NCORES cores sharing one TPG/MISR datapath and reports per-core pass/fail.
// Define BIST_SCHED_RETRY_EN to rerun a core once after its first signature mismatch.
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int NCORES    = 4,
  parameter int NPATTERNS = 16,
  parameter int SIG_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  bist_scheduler_if.slave bus
);

  localparam int IDX_W = clog2_min1(NCORES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCORES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [NCORES-1:0] mask_q;
  logic [NCORES-1:0] mask_d;
  logic [NCORES-1:0] pass_q;
  logic [NCORES-1:0] pass_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              fail_q;
  logic              fail_d;
`ifdef BIST_SCHED_RETRY_EN
  logic [NCORES-1:0] retry_q;
  logic [NCORES-1:0] retry_d;
`endif

  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_last;
  logic              sig_match;
  logic [SIG_W-1:0]  golden_arr [NCORES];

  for (genvar g = 0; g < NCORES; g++) begin : g_golden
    assign golden_arr[g] = bus.golden_sig[g*SIG_W +: SIG_W];
  end

  assign sig_match = (bus.misr_sig == golden_arr[idx_q]);
  assign cnt_clear = (state_q == ST_INIT);
  assign cnt_en    = (state_q == ST_RUN);

  bist_pattern_counter #(
    .NPATTERNS (NPATTERNS)
  ) u_pattern_counter (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_en),
    .terminal_o (cnt_last)
  );

  // fail is resolved on the transition into DONE, when pass_q already holds the last compare.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
`ifdef BIST_SCHED_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d  = bus.core_mask;
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = 1'b0;
`ifdef BIST_SCHED_RETRY_EN
          retry_d = '0;
`endif
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (mask_q[idx_q]) begin
          state_d = ST_INIT;
        end else if (idx_q == LAST_IDX) begin
          fail_d  = |(mask_q & ~pass_q);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_last) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        pass_d[idx_q] = sig_match;
        state_d       = ST_NEXT;
`ifdef BIST_SCHED_RETRY_EN
        if (!sig_match && !retry_q[idx_q]) begin
          retry_d[idx_q] = 1'b1;
          state_d        = ST_INIT;
        end
`endif
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          fail_d  = |(mask_q & ~pass_q);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      fail_q  <= 1'b0;
`ifdef BIST_SCHED_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
`ifdef BIST_SCHED_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign bus.core_sel = idx_q;
  assign bus.tpg_init = (state_q == ST_INIT);
  assign bus.tpg_en   = (state_q == ST_RUN);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.pass_vec = pass_q;
  assign bus.fail     = fail_q;
`ifdef BIST_SCHED_RETRY_EN
  assign bus.retry_vec = retry_q;
`endif

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed schedules for bist_scheduler; expected results are queued at start and checked by a monitor on done.
`timescale 1ns/1ps
module tb_bist_scheduler;

  localparam int NCORES    = 4;
  localparam int NPATTERNS = 16;
  localparam int SIG_W     = 8;

  localparam logic [31:0] GOLD_OK   = {8'h6F, 8'h5E, 8'h4D, 8'h3C};
  localparam logic [31:0] GOLD_BAD2 = {8'h6F, 8'h5F, 8'h4D, 8'h3C};

  typedef struct {
    logic [3:0] pass;
    logic       fail;
    int         doneCycle;
    int         enCount;
    int         initCount;
    logic [3:0] initSeen;
    logic [3:0] retry;
  } exp_t;

  logic clk;
  logic reset;

  int   cycleCnt     = 0;
  int   checks       = 0;
  int   errors       = 0;
  logic stimDone     = 1'b0;
  logic corruptCore0 = 1'b0;

  exp_t doneQ [$];
  int   idleQ [$];

  logic [7:0] misrBase [4] = '{8'h3C, 8'h4D, 8'h5E, 8'h6F};

  int   core0Runs     = 0;
  logic modelPrevBusy = 1'b0;

  logic       monPrevBusy = 1'b0;
  logic       postDone    = 1'b0;
  int         startCycle  = 0;
  int         enCnt       = 0;
  int         initCnt     = 0;
  logic [3:0] initSeen    = 4'b0;
  exp_t       lastExp;

  bist_scheduler_if #(.NCORES(NCORES), .SIG_W(SIG_W)) bus ();

  bist_scheduler #(
    .NCORES    (NCORES),
    .NPATTERNS (NPATTERNS),
    .SIG_W     (SIG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Datapath stand-in: each core has a fixed signature; core 0 can be spoiled on its first run of a schedule.
  assign bus.misr_sig = misrBase[bus.core_sel] ^
                        ((corruptCore0 && core0Runs == 1 && bus.core_sel == 2'd0) ? 8'h5A : 8'h00);

  always @(negedge clk) begin
    if (bus.busy && !modelPrevBusy) core0Runs = 0;
    if (bus.tpg_init && bus.core_sel == 2'd0) core0Runs = core0Runs + 1;
    modelPrevBusy = bus.busy;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t makeExp(input logic [3:0] pass, input logic fail, input int doneCycle,
                                   input int enCount, input int initCount, input logic [3:0] seen,
                                   input logic [3:0] retry);
    exp_t e;
    e.pass      = pass;
    e.fail      = fail;
    e.doneCycle = doneCycle;
    e.enCount   = enCount;
    e.initCount = initCount;
    e.initSeen  = seen;
    e.retry     = retry;
    return e;
  endfunction

  // Monitor: idle snapshots by cycle tag, schedule results on done, held outputs one cycle later.
  always @(negedge clk) begin
    if (postDone) begin
      postDone = 1'b0;
      checkOutput("post_busy", 32'(bus.busy), 32'd0);
      checkOutput("post_done", 32'(bus.done), 32'd0);
      checkOutput("held_pass_vec", 32'(bus.pass_vec), 32'(lastExp.pass));
      checkOutput("held_fail", 32'(bus.fail), 32'(lastExp.fail));
    end
    if (idleQ.size() > 0 && idleQ[0] <= cycleCnt) begin
      void'(idleQ.pop_front());
      checkOutput("idle_core_sel", 32'(bus.core_sel), 32'd0);
      checkOutput("idle_tpg_init", 32'(bus.tpg_init), 32'd0);
      checkOutput("idle_tpg_en", 32'(bus.tpg_en), 32'd0);
      checkOutput("idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("idle_done", 32'(bus.done), 32'd0);
      checkOutput("idle_pass_vec", 32'(bus.pass_vec), 32'd0);
      checkOutput("idle_fail", 32'(bus.fail), 32'd0);
    end
    if (bus.busy && !monPrevBusy) begin
      startCycle = cycleCnt;
      enCnt      = 0;
      initCnt    = 0;
      initSeen   = 4'b0;
    end
    if (bus.tpg_en) enCnt++;
    if (bus.tpg_init) begin
      initCnt++;
      initSeen[bus.core_sel] = 1'b1;
    end
    if (bus.done) begin
      if (doneQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=done expected=no_done");
      end else begin
        lastExp = doneQ.pop_front();
        checkOutput("done_cycle", 32'(cycleCnt - startCycle + 1), 32'(lastExp.doneCycle));
        checkOutput("pass_vec", 32'(bus.pass_vec), 32'(lastExp.pass));
        checkOutput("fail", 32'(bus.fail), 32'(lastExp.fail));
        checkOutput("busy_at_done", 32'(bus.busy), 32'd1);
        checkOutput("tpg_en_cycles", 32'(enCnt), 32'(lastExp.enCount));
        checkOutput("tpg_init_pulses", 32'(initCnt), 32'(lastExp.initCount));
        checkOutput("cores_selected", 32'(initSeen), 32'(lastExp.initSeen));
`ifdef BIST_SCHED_RETRY_EN
        checkOutput("retry_vec", 32'(bus.retry_vec), 32'(lastExp.retry));
`endif
        postDone = 1'b1;
      end
    end
    monPrevBusy = bus.busy;
    if (stimDone) begin
      checkOutput("pending_expectations", 32'(doneQ.size() + idleQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] golden, input logic corrupt,
                               input logic pushExp, input exp_t e);
    bus.core_mask  = mask;
    bus.golden_sig = golden;
    corruptCore0   = corrupt;
    bus.start      = 1'b1;
    if (pushExp) doneQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (doneQ.size() == 0 && idleQ.size() == 0 && !bus.busy) break;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t expAll;
    exp_t expBad2;
    exp_t expNone;
    exp_t expLast;
    exp_t expRetry;

    expAll  = makeExp(4'b1111, 1'b0, 81, 64, 4, 4'b1111, 4'b0000);
    expNone = makeExp(4'b0000, 1'b0, 5, 0, 0, 4'b0000, 4'b0000);
    expLast = makeExp(4'b1000, 1'b0, 24, 16, 1, 4'b1000, 4'b0000);
`ifdef BIST_SCHED_RETRY_EN
    expBad2  = makeExp(4'b0001, 1'b1, 61, 48, 3, 4'b0101, 4'b0100);
    expRetry = makeExp(4'b0001, 1'b0, 42, 32, 2, 4'b0001, 4'b0001);
`else
    expBad2  = makeExp(4'b0001, 1'b1, 43, 32, 2, 4'b0101, 4'b0000);
    expRetry = makeExp(4'b0000, 1'b1, 24, 16, 1, 4'b0001, 4'b0000);
`endif

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.core_mask  = 4'b0;
    bus.golden_sig = GOLD_OK;
    repeat (2) @(negedge clk);
    idleQ.push_back(cycleCnt + 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] all cores enabled, all signatures match");
    applyStimulus(4'b1111, GOLD_OK, 1'b0, 1'b1, expAll);
    waitDrain();

    $display("[TB] mask 0101, core 2 golden wrong");
    applyStimulus(4'b0101, GOLD_BAD2, 1'b0, 1'b1, expBad2);
    waitDrain();

    $display("[TB] empty mask");
    applyStimulus(4'b0000, GOLD_OK, 1'b0, 1'b1, expNone);
    waitDrain();

    $display("[TB] second start during core 1 RUN is ignored");
    applyStimulus(4'b1111, GOLD_OK, 1'b0, 1'b1, expAll);
    repeat (24) @(negedge clk);
    bus.core_mask = 4'b0000;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.core_mask = 4'b1111;
    waitDrain();

    $display("[TB] reset during core 2 RUN aborts, then full rerun");
    applyStimulus(4'b1111, GOLD_OK, 1'b0, 1'b0, expAll);
    repeat (49) @(negedge clk);
    reset = 1'b1;
    idleQ.push_back(cycleCnt + 1);
    @(negedge clk);
    reset = 1'b0;
    waitDrain();
    applyStimulus(4'b1111, GOLD_OK, 1'b0, 1'b1, expAll);
    waitDrain();

    $display("[TB] only last core enabled");
    applyStimulus(4'b1000, GOLD_OK, 1'b0, 1'b1, expLast);
    waitDrain();

    $display("[TB] core 0 mismatches on its first run only");
    applyStimulus(4'b0001, GOLD_OK, 1'b1, 1'b1, expRetry);
    waitDrain();

    stimDone = 1'b1;
  end

endmodule
